// File: rtl/decode_div_65s_26ns_40_seq.sv
// Iterative radix-2 restoring divider: signed din0 / unsigned din1 -> saturated signed quotient.
// One quotient bit per enabled cycle, start/done handshake, ce-gated like the multiplier cores.
module decode_div_65s_26ns_40_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 65,
    parameter int din1_WIDTH = 26,
    parameter int dout_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CW = $clog2(din0_WIDTH + 1);
    localparam int RW = din1_WIDTH + 1;

    // ID is an instance tag only.
    if (ID < 0) begin : g_id_tag
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    neg;
    logic [din0_WIDTH-1:0]   dvd;
    logic [din0_WIDTH-1:0]   quo;
    logic [din1_WIDTH-1:0]   dvs;
    logic [RW-1:0]           prem;
    logic [CW-1:0]           cnt;

    logic [RW-1:0]           shifted;
    logic [RW:0]             trial;
    logic                    q_bit;
    logic [din0_WIDTH-1:0]   din0_mag;
    logic                    pos_ovf;
    logic                    neg_ovf;
    logic [dout_WIDTH-1:0]   q_fix;
    logic [dout_WIDTH-1:0]   max_pos;
    logic [dout_WIDTH-1:0]   min_neg;

    // The partial remainder stays below the divisor, so the shifted value fits in RW bits.
    always_comb begin
        shifted  = {prem[RW-2:0], dvd[din0_WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs};
        q_bit    = ~trial[RW];
        din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
        max_pos  = {1'b0, {(dout_WIDTH-1){1'b1}}};
        min_neg  = {1'b1, {(dout_WIDTH-1){1'b0}}};
        pos_ovf  = |quo[din0_WIDTH-1:dout_WIDTH-1];
        neg_ovf  = (|quo[din0_WIDTH-1:dout_WIDTH])
                 | (quo[dout_WIDTH-1] & (|quo[dout_WIDTH-2:0]));
        q_fix    = neg ? -quo[dout_WIDTH-1:0] : quo[dout_WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            neg   <= 1'b0;
            dvd   <= '0;
            quo   <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else if (ce) begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg  <= din0[din0_WIDTH-1];
                        dvd  <= din0_mag;
                        dvs  <= din1;
                        prem <= '0;
                        quo  <= '0;
                        cnt  <= CW'(din0_WIDTH);
                        dout <= '0;
                        rem  <= '0;
                        ovf  <= 1'b0;
                        dz   <= 1'b0;
                    end
                end
                CALC: begin
                    prem <= q_bit ? trial[RW-1:0] : shifted;
                    dvd  <= {dvd[din0_WIDTH-2:0], 1'b0};
                    quo  <= {quo[din0_WIDTH-2:0], q_bit};
                    cnt  <= cnt - CW'(1);
                end
                // Sign restore and saturation happen once, on the full-width magnitude.
                FIX: begin
                    if (dvs == '0) begin
                        dz   <= 1'b1;
                        ovf  <= 1'b0;
                        rem  <= '0;
                        dout <= neg ? min_neg : max_pos;
                    end else if (neg) begin
                        ovf  <= neg_ovf;
                        dout <= neg_ovf ? min_neg : q_fix;
                        rem  <= -prem;
                    end else begin
                        ovf  <= pos_ovf;
                        dout <= pos_ovf ? max_pos : q_fix;
                        rem  <= prem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_div_65s_26ns_40_seq.sv
// Directed bench for decode_div_65s_26ns_40_seq: hand-computed quotients, latency, flags and reset abort.
module tb_decode_div_65s_26ns_40_seq;

    localparam logic [39:0] MAX_Q = 40'h7F_FFFF_FFFF;
    localparam logic [39:0] MIN_Q = 40'h80_0000_0000;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [64:0] din0;
    logic [25:0] din1;
    logic        busy;
    logic        done;
    logic [39:0] dout;
    logic [26:0] rem;
    logic        ovf;
    logic        dz;

    int n_checks;
    int n_fail;
    int lat;
    int busy_cnt;
    bit seen_done;

    decode_div_65s_26ns_40_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [64:0] a, input logic [25:0] b);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from the start edge (=1) until done is seen; optional mid-op disturbances.
    task automatic wait_done(input bit disturb, output int edges, output int bcnt);
        edges = 1;
        bcnt  = busy ? 1 : 0;
        while (!done && edges < 300) begin
            if (disturb) begin
                if (edges == 5) begin
                    din0 = 65'd999999;
                    din1 = 26'd3;
                end
                start = (edges == 20);
                ce    = !(edges >= 30 && edges < 40);
            end
            @(negedge clk);
            edges++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        ce    = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [64:0] a, input logic [25:0] b,
                          input bit disturb, input int exp_lat, input logic [39:0] exp_q,
                          input logic [26:0] exp_r, input logic exp_ovf, input logic exp_dz);
        start_op(a, b);
        chk({tag, " busy_after_start"}, busy, 1'b1);
        wait_done(disturb, lat, busy_cnt);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, " dout"}, dout, exp_q);
        chk({tag, " rem"}, rem, exp_r);
        chk({tag, " ovf"}, ovf, exp_ovf);
        chk({tag, " dz"}, dz, exp_dz);
        @(negedge clk);
        chk({tag, " done_pulse_ends"}, done, 1'b0);
        chk({tag, " busy_ends"}, busy, 1'b0);
        chk({tag, " dout_holds"}, dout, exp_q);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ce       = 1'b1;
        start    = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset dout", dout, 40'd0);
        chk("reset rem", rem, 27'd0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset dz", dz, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        run_op("pos_1000_7", 65'd1000, 26'd7, 1'b0, 67, 40'd142, 27'd6, 1'b0, 1'b0);
        run_op("neg_1000_7", -65'sd1000, 26'd7, 1'b0, 67, {-40'sd142}, {-27'sd6}, 1'b0, 1'b0);
        run_op("neg_edge_exact", -65'sd1649267441664, 26'd3, 1'b0, 67, MIN_Q, 27'd0, 1'b0, 1'b0);
        run_op("pos_sat", 65'd1 << 50, 26'd1, 1'b0, 67, MAX_Q, 27'd0, 1'b1, 1'b0);
        run_op("neg_sat_min", 65'h1_0000_0000_0000_0000, 26'd1, 1'b0, 67, MIN_Q, 27'd0, 1'b1, 1'b0);

        start_op(65'd5, 26'd0);
        chk("flags_cleared_at_start ovf", ovf, 1'b0);
        wait_done(1'b0, lat, busy_cnt);
        chk("dz_pos latency", lat, 67);
        chk("dz_pos dout", dout, MAX_Q);
        chk("dz_pos rem", rem, 27'd0);
        chk("dz_pos ovf", ovf, 1'b0);
        chk("dz_pos dz", dz, 1'b1);
        @(negedge clk);

        run_op("dz_neg", -65'sd5, 26'd0, 1'b0, 67, MIN_Q, 27'd0, 1'b0, 1'b1);
        run_op("ce_gap_ignored_start", 65'd1000, 26'd7, 1'b1, 77, 40'd142, 27'd6, 1'b0, 1'b0);

        start_op(65'd1000, 26'd7);
        repeat (29) @(negedge clk);
        chk("abort busy_before_reset", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort dout", dout, 40'd0);
        chk("abort rem", rem, 27'd0);
        chk("abort ovf", ovf, 1'b0);
        chk("abort dz", dz, 1'b0);
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort no_done", seen_done, 1'b0);

        run_op("after_abort", 65'd1000, 26'd7, 1'b0, 67, 40'd142, 27'd6, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_div_65s_26ns_40_seq.md
Name: decode_div_65s_26ns_40_seq

Overview:
- Iterative signed-by-unsigned divider for the decode datapath.
- Inverse of the 40s×26ns→65 multiply stage: recovers a 40-bit signed value from a 65-bit signed product and a 26-bit unsigned factor.
- Used where decode rescales accumulated products back to feature-map precision.
- Radix-2 restoring algorithm, one quotient bit per enabled cycle, start/done handshake, clock-enable gating matching the multiplier cores.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 65, dividend width (signed).
- din1_WIDTH, 26, divisor width (unsigned).
- dout_WIDTH, 40, quotient width (signed).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; all state advances only when ce=1.
- start  input  1  request; sampled only in IDLE with ce=1.
- din0  input  din0_WIDTH  signed dividend.
- din1  input  din1_WIDTH  unsigned divisor.
- busy  output  1  high from accepted start until done cycle inclusive.
- done  output  1  one-cycle pulse; results valid.
- dout  output  dout_WIDTH  signed quotient, truncated toward zero.
- rem  output  din1_WIDTH+1  signed remainder; sign follows dividend; zero dividend gives rem=0.
- ovf  output  1  quotient saturated.
- dz  output  1  divide by zero.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, ovf, dz, dout, rem all 0.
  - Internal registers cleared.
  - Applies mid-operation; the operation is aborted with no done pulse.
- States: IDLE → CALC → FIX → DONE → IDLE. All transitions require ce=1; ce=0 freezes state, counter and outputs, including done.
- IDLE, start=1:
  - Latch sign of din0, |din0| as a din0_WIDTH-bit unsigned value (|−2^64| = 2^64 fits), and din1.
  - Clear partial remainder; counter = din0_WIDTH; busy=1; go to CALC.
  - done and flags from the previous op are cleared at this edge.
- CALC, each enabled cycle:
  - Shift the next dividend MSB into the partial remainder (din1_WIDTH+1 bits).
  - Trial subtract divisor; if non-negative, keep the difference and set quotient bit=1, else 0.
  - Decrement counter; when counter reaches 1, go to FIX at that edge.
  - Exactly din0_WIDTH CALC cycles.
- FIX, one cycle:
  - Negate quotient and remainder if the dividend was negative.
  - Saturate: if the signed quotient is outside [−2^39, 2^39−1], dout=2^39−1 (positive) or −2^39 (negative), ovf=1.
  - Divisor 0: dz=1, dout=2^39−1 if dividend ≥0, else −2^39; rem=0; ovf=0. Latency is unchanged.
  - Register outputs; go to DONE.
- DONE: done=1 and busy=1 for one enabled cycle, then IDLE with busy=0.
- Outputs dout/rem/ovf/dz hold their values until the next accepted start or reset.
- Latency: done is high in the cycle starting din0_WIDTH+2 enabled edges after the start edge (67 by default).
- start while busy (CALC/FIX/DONE) is ignored, not queued.
- start may be asserted in the cycle immediately after done (IDLE).
- Operands are sampled only at the start edge; later din0/din1 changes have no effect.
- Internal quotient accumulator is din0_WIDTH bits wide; saturation is applied only at FIX.

Test Plan:
- din0=1000, din1=7, start one cycle, ce=1 → done at start edge+67; dout=142, rem=6, ovf=0, dz=0; busy high 67 cycles.
- din0=−1000, din1=7 → dout=−142, rem=−6. Then din0=−(2^39)·3, din1=3 → dout=−549755813888, ovf=0 (exact multiply round-trip at the range edge).
- din0=2^50, din1=1 → dout=549755813887, ovf=1. Then din0=−2^64, din1=1 → dout=−549755813888, ovf=1.
- din0=5, din1=0 → dz=1, dout=549755813887, rem=0, done still at +67. din0=−5, din1=0 → dout=−549755813888.
- Start 1000/7; toggle ce low for 10 cycles mid-CALC → done at +77. A second start pulsed at +20 is ignored. New operands changed at +5 do not affect the result.
- Start an op, assert reset at +30 → all outputs 0 immediately (asynchronous), no done pulse. After release, 1000/7 completes normally.
